trigger_pulse_bank: RTL and testbench
=====================================

# trigger_pulse_bank

Multi-channel APB3 pulse generator driving solenoid/actuator trigger lines. Successor to the single-channel countdown trigger, with a configurable channel count, programmable on-time, off-time and repeat count per channel, an abort command, readable status, and a simultaneous-fire command. Sits on the APB3 peripheral bus beside the other fabric peripherals; each `trig` bit drives one solenoid driver input.

## Interface
- `NCH`, 4: number of channels, 1..8.
- `CW`, 24: width of the on-time, off-time and repeat counters.
- `HOLDOFF`, 1000: post-train lockout in PCLK cycles; used only with `TRIG_HOLDOFF_EN`.
- `PCLK` in 1: clock.
- `PRESET` in 1: reset, asynchronous, active-high.
- `PSEL`, `PENABLE`, `PWRITE` in 1: APB3 control.
- `PADDR` in 32: only [7:0] decoded.
- `PWDATA` in 32: write data.
- `PRDATA` out 32: read data, combinational from the address.
- `PREADY` out 1: tied 1.
- `PSLVERR` out 1: 1 during an access phase to an unmapped offset or a channel index ≥ NCH; otherwise 0.
- `trig` out NCH: registered trigger outputs, active-high.

## Operation
- Access = PSEL & PENABLE. Channel c registers are at 0x10·c (c < NCH):
  - +0x0 WIDTH: read/write.
  - +0x4 GAP: read/write.
  - +0x8 REPEAT: read/write.
  - +0xC CMD/STATUS. Write: bit0 START, bit1 ABORT. Read: [1:0] state, bit2 ERR, [31:8] remaining pulses, truncated to 24 bits.
- Global register at 0x80. Write: bits[NCH-1:0] START mask. Read: busy bitmap, where busy means the channel is not IDLE.
- WIDTH, GAP and REPEAT take PWDATA[CW-1:0]. Reads return them zero-extended. All reset to 0.
- On an accepted START, WIDTH, GAP and REPEAT are copied to per-channel shadows. Later register writes affect only the next start.
- Per-channel FSM:
  - IDLE → ON on START when WIDTH≠0.
  - ON holds `trig`=1 for WIDTH cycles. Then, if remaining>1, go to OFF; else go to IDLE (or HOLD with the macro).
  - OFF holds `trig`=0 for max(GAP,1) cycles, decrements remaining, then returns to ON.
  - ABORT from any state forces `trig`=0 next cycle and goes to IDLE (or HOLD).
- REPEAT=0 is treated as 1.
- START is rejected and sets sticky ERR in two cases: WIDTH=0, or channel not IDLE. The FSM is unaffected. ERR clears on the next accepted START.
- If ABORT and START are written together, ABORT wins and START is ignored without setting ERR.
- A global START-mask bit acts exactly as a per-channel START. Channels started by one mask write have `trig` aligned to the same cycle.
- Reads have no side effects.

## Timing
- Reset: `trig`=0, every FSM in IDLE, counters 0, ERR 0, all registers 0, PRDATA tracks the decode (0 for the status of an idle channel). Reset asserted mid-pulse drops `trig` asynchronously.
- START sampled at edge k: `trig` is high after edge k. It stays high for exactly WIDTH cycles and is low after edge k+WIDTH.
- Train period is WIDTH+max(GAP,1) cycles. Total high cycles = WIDTH·max(REPEAT,1).
- ABORT sampled at edge k: `trig` is low after edge k.
- Status reflects the state after the most recent edge. PRDATA is valid in the access phase with zero wait states.
- Counters never wrap. Maximum WIDTH is 2^CW−1 cycles.

## Configuration
- `TRIG_HOLDOFF_EN` defined:
  - Adds a HOLD state entered at train end or on ABORT.
  - The channel stays in HOLD for HOLDOFF cycles with `trig`=0, then goes to IDLE.
  - START during HOLD is rejected and sets ERR.
  - Status state encodes HOLD as 3.
- Undefined: no HOLD state and the `HOLDOFF` parameter is ignored. Train end and ABORT go directly to IDLE, and START is accepted on the next cycle.

## Structure
- Package `trigger_pkg` holds:
  - The state enum: IDLE=0, ON=1, OFF=2, HOLD=3.
  - Register offset constants: WIDTH/GAP/REPEAT/CMD, GLOBAL=0x80.
  - Command bit positions.
- Sub-module `trigger_channel` is instantiated NCH times. It contains the shadows, counters, FSM and `trig` flop for one channel.
- The top level holds APB decode, register storage and the PRDATA mux.

## Test plan
- Single pulse: ch0 WIDTH=5, REPEAT=0, START → `trig[0]` high exactly 5 cycles from the sampled edge; status returns to IDLE with remaining 0.
- Burst: ch1 WIDTH=3, GAP=0, REPEAT=4 → pattern 3 high/1 low ×4, 12 high cycles total. Rewriting WIDTH=9 mid-train does not change the train.
- Error cases:
  - START with WIDTH=0 → ERR=1 and no pulse.
  - START while ON → ERR=1 and the train continues unchanged.
  - A valid START afterwards clears ERR.
- Abort/reset: ABORT at cycle 2 of a 100-cycle pulse → `trig` low the next cycle. ABORT+START in the same write → IDLE, no ERR. PRESET mid-burst → `trig`=0 immediately and all registers read 0.
- Global mask 0xF with NCH=4 → all `trig` bits rise on the same edge. A read of 0xC0 → PSLVERR=1 and PRDATA=0.
- With `TRIG_HOLDOFF_EN` and HOLDOFF=10: START at cycle 5 after train end → ERR=1; START at cycle 11 → accepted.

Source files
------------

// File: rtl/trigger_pkg.sv
// Shared state encoding, register map and status packing for the trigger pulse bank.
package trigger_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        HOLD = 2'd3
    } trig_state_e;

    localparam logic [3:0] OFS_WIDTH   = 4'h0;
    localparam logic [3:0] OFS_GAP     = 4'h4;
    localparam logic [3:0] OFS_REPEAT  = 4'h8;
    localparam logic [3:0] OFS_CMD     = 4'hC;
    localparam logic [7:0] ADDR_GLOBAL = 8'h80;

    localparam int CMD_START_BIT = 0;
    localparam int CMD_ABORT_BIT = 1;

    // Status word: [31:8] remaining pulses, [2] sticky error, [1:0] state.
    function automatic logic [31:0] pack_status(input trig_state_e st,
                                                input logic        err,
                                                input logic [23:0] rem);
        return {rem, 5'b00000, err, st};
    endfunction

endpackage

// File: rtl/trigger_channel.sv
// One trigger channel: start shadows, on/off/repeat counters, FSM and trig flop.
// Optional post-train lockout state when TRIG_HOLDOFF_EN is defined.
module trigger_channel
    import trigger_pkg::*;
#(
    parameter int CW      = 24,
    parameter int HOLDOFF = 1000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [CW-1:0] width_i,
    input  logic [CW-1:0] gap_i,
    input  logic [CW-1:0] repeat_i,
    output logic          trig_o,
    output trig_state_e   state_o,
    output logic          err_o,
    output logic [CW-1:0] remaining_o
);

    localparam logic [CW-1:0] ONE = CW'(1);

`ifdef TRIG_HOLDOFF_EN
    localparam int              HW        = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [HW-1:0]   HOLD_LOAD = HW'(HOLDOFF);
    localparam logic [HW-1:0]   HONE      = HW'(1);
    localparam trig_state_e     TAIL      = (HOLDOFF > 0) ? HOLD : IDLE;
    logic [HW-1:0] hcnt_q, hcnt_d;
`else
    localparam trig_state_e     TAIL      = IDLE;
    localparam int              unused_holdoff = HOLDOFF;
`endif

    trig_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [CW-1:0] wsh_q, wsh_d;
    logic [CW-1:0] gsh_q, gsh_d;
    logic          err_q, err_d;
    logic          trig_q;
    logic          start_ok;
    logic          start_bad;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        wsh_d     = wsh_q;
        gsh_d     = gsh_q;
        err_d     = err_q;
        start_ok  = start_i && !abort_i && (state_q == IDLE) && (width_i != '0);
        start_bad = start_i && !abort_i && !start_ok;

        if (abort_i) begin
            state_d = TAIL;
            cnt_d   = '0;
            rem_d   = '0;
        end else if (start_ok) begin
            state_d = ON;
            cnt_d   = width_i;
            wsh_d   = width_i;
            gsh_d   = (gap_i == '0) ? ONE : gap_i;
            rem_d   = (repeat_i == '0) ? ONE : repeat_i;
            err_d   = 1'b0;
        end else begin
            if (start_bad) begin
                err_d = 1'b1;
            end
            case (state_q)
                ON: begin
                    if (cnt_q > ONE) begin
                        cnt_d = cnt_q - ONE;
                    end else if (rem_q > ONE) begin
                        state_d = OFF;
                        cnt_d   = gsh_q;
                    end else begin
                        state_d = TAIL;
                        cnt_d   = '0;
                        rem_d   = '0;
                    end
                end
                OFF: begin
                    if (cnt_q > ONE) begin
                        cnt_d = cnt_q - ONE;
                    end else begin
                        state_d = ON;
                        cnt_d   = wsh_q;
                        rem_d   = rem_q - ONE;
                    end
                end
`ifdef TRIG_HOLDOFF_EN
                HOLD: begin
                    if (hcnt_q <= HONE) begin
                        state_d = IDLE;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef TRIG_HOLDOFF_EN
    // Lockout counter reloads on every entry into HOLD, including a re-abort while held.
    always_comb begin
        hcnt_d = hcnt_q;
        if (state_d == HOLD && (abort_i || state_q != HOLD)) begin
            hcnt_d = HOLD_LOAD;
        end else if (state_q == HOLD && hcnt_q > HONE) begin
            hcnt_d = hcnt_q - HONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            wsh_q   <= '0;
            gsh_q   <= '0;
            err_q   <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            wsh_q   <= wsh_d;
            gsh_q   <= gsh_d;
            err_q   <= err_d;
            trig_q  <= (state_d == ON);
        end
    end

    assign trig_o      = trig_q;
    assign state_o     = state_q;
    assign err_o       = err_q;
    assign remaining_o = rem_q;

endmodule

// File: rtl/trigger_pulse_bank.sv
// APB3 multi-channel trigger pulse generator: decode, per-channel registers, read mux.
// Optional post-train lockout selected by the TRIG_HOLDOFF_EN macro.
module trigger_pulse_bank
    import trigger_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int CW      = 24,
    parameter int HOLDOFF = 1000
) (
    input  logic           PCLK,
    input  logic           PRESET,
    input  logic           PSEL,
    input  logic           PENABLE,
    input  logic           PWRITE,
    input  logic [31:0]    PADDR,
    input  logic [31:0]    PWDATA,
    output logic [31:0]    PRDATA,
    output logic           PREADY,
    output logic           PSLVERR,
    output logic [NCH-1:0] trig
);

    logic          access;
    logic          wr;
    logic [3:0]    ch_idx;
    logic [3:0]    ofs;
    logic          ofs_ok;
    logic          ch_hit;
    logic          glb_hit;
    logic          glb_wr;
    logic          unused_bits;

    logic [CW-1:0] width_rd [NCH];
    logic [CW-1:0] gap_rd   [NCH];
    logic [CW-1:0] rep_rd   [NCH];
    logic [CW-1:0] rem_rd   [NCH];
    trig_state_e   st_rd    [NCH];
    logic [NCH-1:0] err_rd;
    logic [NCH-1:0] busy;

    assign access  = PSEL && PENABLE;
    assign wr      = access && PWRITE;
    assign ch_idx  = PADDR[7:4];
    assign ofs     = PADDR[3:0];
    assign ofs_ok  = (ofs == OFS_WIDTH) || (ofs == OFS_GAP) ||
                     (ofs == OFS_REPEAT) || (ofs == OFS_CMD);
    assign ch_hit  = (32'(ch_idx) < 32'(NCH)) && ofs_ok;
    assign glb_hit = (PADDR[7:0] == ADDR_GLOBAL);
    assign glb_wr  = wr && glb_hit;

    assign PREADY  = 1'b1;
    assign PSLVERR = access && !(ch_hit || glb_hit);

    assign unused_bits = ^{PADDR[31:8], PWDATA};

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        localparam logic [3:0] CI = 4'(c);

        logic [CW-1:0] width_q;
        logic [CW-1:0] gap_q;
        logic [CW-1:0] rep_q;
        logic          sel;
        logic          start;
        logic          abort;

        assign sel = wr && ch_hit && (ch_idx == CI);

        always_ff @(posedge PCLK or posedge PRESET) begin
            if (PRESET) begin
                width_q <= '0;
                gap_q   <= '0;
                rep_q   <= '0;
            end else if (sel) begin
                case (ofs)
                    OFS_WIDTH:  width_q <= PWDATA[CW-1:0];
                    OFS_GAP:    gap_q   <= PWDATA[CW-1:0];
                    OFS_REPEAT: rep_q   <= PWDATA[CW-1:0];
                    default: ;
                endcase
            end
        end

        // A global mask bit is indistinguishable from a per-channel START.
        assign start = (sel && (ofs == OFS_CMD) && PWDATA[CMD_START_BIT]) || (glb_wr && PWDATA[c]);
        assign abort = sel && (ofs == OFS_CMD) && PWDATA[CMD_ABORT_BIT];

        trigger_channel #(
            .CW      (CW),
            .HOLDOFF (HOLDOFF)
        ) u_ch (
            .clk_i       (PCLK),
            .rst_i       (PRESET),
            .start_i     (start),
            .abort_i     (abort),
            .width_i     (width_q),
            .gap_i       (gap_q),
            .repeat_i    (rep_q),
            .trig_o      (trig[c]),
            .state_o     (st_rd[c]),
            .err_o       (err_rd[c]),
            .remaining_o (rem_rd[c])
        );

        assign width_rd[c] = width_q;
        assign gap_rd[c]   = gap_q;
        assign rep_rd[c]   = rep_q;
        assign busy[c]     = (st_rd[c] != IDLE);
    end

    always_comb begin
        PRDATA = '0;
        if (glb_hit) begin
            PRDATA[NCH-1:0] = busy;
        end else if (ch_hit) begin
            for (int c = 0; c < NCH; c++) begin
                if (ch_idx == 4'(c)) begin
                    case (ofs)
                        OFS_WIDTH:  PRDATA = 32'(width_rd[c]);
                        OFS_GAP:    PRDATA = 32'(gap_rd[c]);
                        OFS_REPEAT: PRDATA = 32'(rep_rd[c]);
                        OFS_CMD:    PRDATA = pack_status(st_rd[c], err_rd[c], 24'(rem_rd[c]));
                        default:    PRDATA = '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_trigger_pulse_bank.sv
// Scoreboard bench for trigger_pulse_bank: stimulus queues expectations, a monitor checks them.
module tb_trigger_pulse_bank;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } rd_t;

    logic        PCLK;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [3:0]  trig;

    logic        smp;
    int          errors;
    int          checks;

    rd_t         rd_q [$];
    string       rd_n [$];
    logic [3:0]  tr_q [$];
    string       tr_n [$];
    rd_t         re;
    string       rn;
    logic [3:0]  te;
    string       tn;

    trigger_pulse_bank #(
        .NCH     (4),
        .CW      (24),
        .HOLDOFF (10)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .trig    (trig)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Monitor: pops an expectation whenever a read access or a trig sample is presented.
    always @(negedge PCLK) begin
        if (PSEL && PENABLE && !PWRITE) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: read at 0x%02h with no expectation queued", PADDR[7:0]);
            end else begin
                re = rd_q.pop_front();
                rn = rd_n.pop_front();
                if ({PSLVERR, PRDATA} !== {re.err, re.data}) begin
                    errors++;
                    $display("FAIL %s: got slverr=%0b prdata=0x%08h, expected slverr=%0b prdata=0x%08h",
                             rn, PSLVERR, PRDATA, re.err, re.data);
                end
            end
        end
        if (smp) begin
            checks++;
            if (tr_q.size() == 0) begin
                errors++;
                $display("FAIL trig_unexpected: sample strobe with no expectation queued");
            end else begin
                te = tr_q.pop_front();
                tn = tr_n.pop_front();
                if (trig !== te) begin
                    errors++;
                    $display("FAIL %s: got trig=%04b, expected trig=%04b", tn, trig, te);
                end
            end
        end
    end

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = {24'h0, a}; PWDATA = d;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, input logic [31:0] exp, input logic experr, input string nm);
        rd_q.push_back({experr, exp});
        rd_n.push_back(nm);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = {24'h0, a};
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Checks trig for the cycle following the most recent edge, then advances one cycle.
    task automatic step_chk(input logic [3:0] exp, input string nm);
        tr_q.push_back(exp);
        tr_n.push_back(nm);
        smp = 1'b1;
        @(posedge PCLK); #1 smp = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0; checks = 0; smp = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        PRESET = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        step_chk(4'b0000, "trig_in_reset");
        PRESET = 1'b0;
        apb_read(8'h00, 32'h0, 1'b0, "rst_width0");
        apb_read(8'h0C, 32'h0, 1'b0, "rst_status0");
        apb_read(8'h80, 32'h0, 1'b0, "rst_busy");
        step_chk(4'b0000, "rst_trig");
        apb_read(8'hC0, 32'h0, 1'b1, "slverr_c0");
        apb_read(8'h44, 32'h0, 1'b1, "slverr_ch4");

`ifndef TRIG_HOLDOFF_EN
        // Single 5-cycle pulse on ch0.
        apb_write(8'h00, 32'd5);
        apb_write(8'h08, 32'd0);
        apb_read(8'h00, 32'd5, 1'b0, "ch0_width_rb");
        apb_write(8'h0C, 32'h1);
        for (int i = 0; i < 5; i++) step_chk(4'b0001, "ch0_pulse_high");
        step_chk(4'b0000, "ch0_pulse_end");
        apb_read(8'h0C, 32'h0, 1'b0, "ch0_status_done");

        // Burst on ch1: 3 high / 1 low x4, WIDTH rewritten mid-train.
        apb_write(8'h10, 32'd3);
        apb_write(8'h14, 32'd0);
        apb_write(8'h18, 32'd4);
        apb_write(8'h1C, 32'h1);
        fork
            begin
                for (int i = 0; i < 18; i++)
                    step_chk((i < 16 && (i % 4) < 3) ? 4'b0010 : 4'b0000, "ch1_burst");
            end
            begin
                repeat (4) @(posedge PCLK);
                #1 apb_write(8'h10, 32'd9);
            end
        join
        apb_read(8'h1C, 32'h0, 1'b0, "ch1_status_done");
        apb_read(8'h10, 32'd9, 1'b0, "ch1_width_rewritten");

        // Error cases on ch2.
        apb_write(8'h2C, 32'h1);
        step_chk(4'b0000, "ch2_no_pulse_w0");
        apb_read(8'h2C, 32'h4, 1'b0, "ch2_err_w0");
        apb_write(8'h20, 32'd20);
        apb_write(8'h2C, 32'h1);
        fork
            begin
                for (int i = 0; i < 20; i++) step_chk(4'b0100, "ch2_train_kept");
                step_chk(4'b0000, "ch2_train_end");
            end
            begin
                apb_write(8'h2C, 32'h1);
                apb_read(8'h2C, 32'h0000_0105, 1'b0, "ch2_err_busy");
            end
        join
        apb_read(8'h2C, 32'h4, 1'b0, "ch2_err_sticky");
        apb_write(8'h2C, 32'h1);
        apb_read(8'h2C, 32'h0000_0101, 1'b0, "ch2_err_cleared");
        apb_write(8'h2C, 32'h3);
        step_chk(4'b0000, "ch2_abort_start_trig");
        apb_read(8'h2C, 32'h0, 1'b0, "ch2_abort_start_status");

        // ABORT early in a 100-cycle pulse on ch3.
        apb_write(8'h30, 32'd100);
        apb_write(8'h3C, 32'h1);
        fork
            begin
                step_chk(4'b1000, "ch3_on_c0");
                step_chk(4'b1000, "ch3_on_c1");
                step_chk(4'b0000, "ch3_aborted");
                step_chk(4'b0000, "ch3_stays_low");
            end
            apb_write(8'h3C, 32'h2);
        join
        apb_read(8'h3C, 32'h0, 1'b0, "ch3_status_idle");

        // Global start mask: all channels rise together.
        apb_write(8'h80, 32'hF);
        step_chk(4'b1111, "global_aligned");
        apb_read(8'h80, 32'hF, 1'b0, "global_busy");

        // Reset mid-burst drops trig without a clock edge and clears registers.
        #1 PRESET = 1'b1;
        step_chk(4'b0000, "preset_async_trig");
        PRESET = 1'b0;
        apb_read(8'h00, 32'h0, 1'b0, "preset_ch0_width");
        apb_read(8'h10, 32'h0, 1'b0, "preset_ch1_width");
        apb_read(8'h18, 32'h0, 1'b0, "preset_ch1_repeat");
        apb_read(8'h2C, 32'h0, 1'b0, "preset_ch2_status");
        apb_read(8'h80, 32'h0, 1'b0, "preset_busy");
        step_chk(4'b0000, "preset_trig_idle");
`else
        // Lockout: train ends at edge k+2, HOLD lasts 10 cycles.
        apb_write(8'h00, 32'd2);
        apb_write(8'h0C, 32'h1);
        repeat (5) @(posedge PCLK);
        #1 apb_write(8'h0C, 32'h1);
        apb_read(8'h0C, 32'h7, 1'b0, "hold_start_rejected");
        repeat (2) @(posedge PCLK);
        #1 apb_write(8'h0C, 32'h1);
        apb_read(8'h0C, 32'h0000_0101, 1'b0, "hold_start_accepted");
`endif

        repeat (3) @(posedge PCLK);
        checks++;
        if (rd_q.size() != 0 || tr_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d read and %0d trig expectations pending, expected 0",
                     rd_q.size(), tr_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
